aibcr3aux_osc_scan_ctl: RTL and testbench



---
 rtl/aibcr3aux_osc_scan_ctl_if.sv | 28 ++
 rtl/aibcr3aux_osc_scan_ctl.sv | 127 ++++++++++++
 tb/tb_aibcr3aux_osc_scan_ctl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3aux_osc_scan_ctl_if.sv
// Bus between the aux-oscillator scan controller and its users: the
// request/response side (start, load/unload words, busy/done) and the
// serial chain side (se_n, si, so).
interface aibcr3aux_osc_scan_ctl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic                 capture_en;
    logic [CHAIN_LEN-1:0] load_data;
    logic                 so;
    logic                 se_n;
    logic                 si;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] unload_data;

    // Requester / chain side: issues operations and returns the chain's scan-out.
    modport master (
        output start, capture_en, load_data, so,
        input  se_n, si, busy, done, unload_data
    );

    // Controller side.
    modport slave (
        input  start, capture_en, load_data, so,
        output se_n, si, busy, done, unload_data
    );
endinterface

// File: rtl/aibcr3aux_osc_scan_ctl.sv
// Aux-oscillator scan-chain controller. Serially loads a parallel word into
// the chain (MSB first), optionally pulses one functional capture cycle,
// then unloads the chain back into a parallel register.
module aibcr3aux_osc_scan_ctl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 5
) (
    input  logic cp,
    input  logic cdn,
    inout  wire  vbb,
    inout  wire  vdd,
    inout  wire  vpp,
    inout  wire  vss,
    aibcr3aux_osc_scan_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        UNLOAD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    // Supplies carry no logic; they are only gathered here so they count as read.
    wire unused_supply = &{1'b0, vbb, vdd, vpp, vss};

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] ld_sh;   // remaining load bits, next bit to send in the MSB
    logic                 cap_q;
    logic [CHAIN_LEN-1:0] sr;      // unload shift register, first sample ends in the MSB
    logic                 se_n_q;
    logic                 si_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CHAIN_LEN-1:0] unload_q;

    // Sampled chain word including the bit arriving on this edge.
    logic [CHAIN_LEN-1:0] sr_next;
    assign sr_next = {sr[CHAIN_LEN-2:0], bus.so};

    // Controller FSM with every output registered on cp.
    // NOTE: all state is updated with non-blocking assignments so that every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge cp or negedge cdn) begin
        if (!cdn) begin
            // NOTE: unload_data is a visible output, so it is reset along with
            // the control state rather than left to power up undefined.
            state    <= IDLE;
            cnt      <= '0;
            ld_sh    <= '0;
            cap_q    <= 1'b0;
            sr       <= '0;
            se_n_q   <= 1'b1;
            si_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            unload_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        cap_q  <= bus.capture_en;
                        si_q   <= bus.load_data[CHAIN_LEN-1];
                        ld_sh  <= {bus.load_data[CHAIN_LEN-2:0], 1'b0};
                        se_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr <= sr_next;
                    // NOTE: the count stops at LAST and is cleared on leaving,
                    // so it never wraps regardless of CNT_W headroom.
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        si_q <= 1'b0;
                        se_n_q <= 1'b1;
                        if (cap_q) begin
                            state <= CAPTURE;
                        end else begin
                            state    <= IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            unload_q <= sr_next;
                        end
                    end else begin
                        cnt   <= cnt + 1'b1;
                        si_q  <= ld_sh[CHAIN_LEN-1];
                        ld_sh <= {ld_sh[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                CAPTURE: begin
                    state  <= UNLOAD;
                    cnt    <= '0;
                    se_n_q <= 1'b0;
                    si_q   <= 1'b0;
                end
                UNLOAD: begin
                    sr <= sr_next;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        se_n_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        unload_q <= sr_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.se_n        = se_n_q;
    assign bus.si          = si_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.unload_data = unload_q;

endmodule

// File: tb/tb_aibcr3aux_osc_scan_ctl.sv
// Bench for aibcr3aux_osc_scan_ctl with an 8-flop behavioural scan chain.
module tb_aibcr3aux_osc_scan_ctl;

    localparam int N = 8;

    logic cp;
    logic cdn;
    wire  vbb = 1'b0;
    wire  vdd = 1'b1;
    wire  vpp = 1'b1;
    wire  vss = 1'b0;

    aibcr3aux_osc_scan_ctl_if #(.CHAIN_LEN(N)) bus ();

    aibcr3aux_osc_scan_ctl #(.CHAIN_LEN(N), .CNT_W(5)) dut (
        .cp  (cp),
        .cdn (cdn),
        .vbb (vbb),
        .vdd (vdd),
        .vpp (vpp),
        .vss (vss),
        .bus (bus)
    );

    // Behavioural chain: position 0 takes si, position N-1 drives so.
    // d either holds the current contents or presents a bench value.
    logic [N-1:0] chain;
    logic         d_hold;
    logic [N-1:0] d_val;
    wire  [N-1:0] chain_d = d_hold ? chain : d_val;

    always_ff @(posedge cp or negedge cdn) begin
        if (!cdn)            chain <= '0;
        else if (!bus.se_n)  chain <= {chain[N-2:0], bus.si};
        else                 chain <= chain_d;
    end
    assign bus.so = chain[N-1];

    initial cp = 1'b0;
    always #5 cp = ~cp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] mc;   // model of chain contents at the current sample point

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One idle cycle after a completion: done must have dropped.
    task automatic idle_step();
        @(negedge cp);
        check("done one cycle", 32'(bus.done), 32'd0);
        mc = d_hold ? mc : d_val;
    endtask

    // Issue one operation from an IDLE/done cycle and follow it to completion.
    task automatic run_op(input logic [N-1:0] ld, input logic cap, input logic poke,
                          input int exp_busy, input logic [N-1:0] exp_unl,
                          input logic [N-1:0] exp_chain, input string tag);
        int       n_busy   = 0;
        int       se_hi    = 0;
        int       se_hi_at = -1;
        int       n_si     = 0;
        logic [N-1:0] si_bits = '0;
        bit       got_done = 0;
        bus.start      = 1'b1;
        bus.capture_en = cap;
        bus.load_data  = ld;
        @(negedge cp);
        bus.start      = 1'b0;
        bus.capture_en = ~cap;
        bus.load_data  = ~ld;
        for (int c = 0; c < 64; c++) begin
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (bus.busy) begin
                if (bus.se_n) begin
                    se_hi++;
                    if (se_hi_at < 0) se_hi_at = n_busy;
                end else if (n_si < N) begin
                    si_bits = {si_bits[N-2:0], bus.si};
                    n_si++;
                end
                n_busy++;
            end
            bus.start = poke && (c == 3);
            if (poke && c == 3) bus.load_data = 8'h00;
            @(negedge cp);
        end
        bus.start = 1'b0;
        check({tag, " done seen"},   32'(got_done),  32'd1);
        check({tag, " busy cycles"}, 32'(n_busy),    32'(exp_busy));
        check({tag, " si order"},    32'(si_bits),   32'(ld));
        check({tag, " se_n high"},   32'(se_hi),     cap ? 32'd1 : 32'd0);
        check({tag, " capture pos"}, 32'(se_hi_at),  cap ? 32'(N) : 32'hFFFF_FFFF);
        check({tag, " unload"},      32'(bus.unload_data), 32'(exp_unl));
        check({tag, " chain"},       32'(chain),     32'(exp_chain));
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        mc = exp_chain;
    endtask

    typedef struct {
        logic [N-1:0] ld;
        logic         cap;
        logic         hold;
        logic [N-1:0] dval;
        logic         b2b;
        logic         poke;
        int           exp_busy;
        logic [N-1:0] exp_unl;
        logic [N-1:0] exp_chain;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [N-1:0] r_ld, r_dv, r_pre, r_unl, r_after;
        logic         r_cap, r_hold, r_b2b;
        int           done_cnt;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8,  8'h00, 8'hA5}; // shift-only load
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8,  8'hA5, 8'h3C}; // loopback, start in done cycle
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 17, 8'h5A, 8'h00}; // capture mode
        vecs[3] = '{8'h6E, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8,  8'h5A, 8'h6E}; // start poked while busy
        vecs[4] = '{8'h99, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 17, 8'h99, 8'h00}; // capture of held contents

        cdn = 1'b0;
        bus.start = 1'b0;
        bus.capture_en = 1'b0;
        bus.load_data = '0;
        d_hold = 1'b1;
        d_val = '0;
        mc = '0;

        repeat (3) @(negedge cp);
        check("rst se_n",   32'(bus.se_n),        32'd1);
        check("rst si",     32'(bus.si),          32'd0);
        check("rst busy",   32'(bus.busy),        32'd0);
        check("rst done",   32'(bus.done),        32'd0);
        check("rst unload", 32'(bus.unload_data), 32'd0);
        cdn = 1'b1;
        @(negedge cp);

        // Table-driven directed operations.
        for (int i = 0; i < 5; i++) begin
            if (!vecs[i].b2b) idle_step();
            d_hold = vecs[i].hold;
            d_val  = vecs[i].dval;
            run_op(vecs[i].ld, vecs[i].cap, vecs[i].poke, vecs[i].exp_busy,
                   vecs[i].exp_unl, vecs[i].exp_chain, $sformatf("vec%0d", i));
        end

        // Randomized operations against the chain-level model.
        for (int k = 0; k < 12; k++) begin
            r_ld   = N'($urandom);
            r_dv   = N'($urandom);
            r_cap  = 1'($urandom_range(0, 1));
            r_hold = 1'($urandom_range(0, 1));
            r_b2b  = 1'($urandom_range(0, 1));
            if (!r_b2b) idle_step();
            d_hold = r_hold;
            d_val  = r_dv;
            // The chain picks up d on the start edge, then holds the loaded word.
            r_pre = r_hold ? mc : r_dv;
            if (r_cap) begin
                r_unl   = r_hold ? r_ld : r_dv;
                r_after = '0;
            end else begin
                r_unl   = r_pre;
                r_after = r_ld;
            end
            run_op(r_ld, r_cap, 1'b0, r_cap ? 2 * N + 1 : N, r_unl, r_after,
                   $sformatf("rnd%0d", k));
        end

        // Reset while idle, with a nonzero unload word in place.
        d_hold = 1'b1;
        idle_step();
        r_ld = 8'h00;
        r_unl = bus.unload_data;
        #2 cdn = 1'b0;
        #1;
        check("idle rst se_n",   32'(bus.se_n),        32'd1);
        check("idle rst si",     32'(bus.si),          32'd0);
        check("idle rst busy",   32'(bus.busy),        32'd0);
        check("idle rst done",   32'(bus.done),        32'd0);
        check("idle rst unload", 32'(bus.unload_data), 32'd0);
        @(negedge cp);
        cdn = 1'b1;
        mc = '0;
        @(negedge cp);

        // Reset three cycles into a shift: immediate abort and no done.
        bus.start = 1'b1;
        bus.capture_en = 1'b1;
        bus.load_data = 8'hC3;
        @(negedge cp);
        bus.start = 1'b0;
        repeat (3) @(negedge cp);
        check("mid busy before rst", 32'(bus.busy), 32'd1);
        #2 cdn = 1'b0;
        #1;
        check("mid rst se_n", 32'(bus.se_n), 32'd1);
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst si",   32'(bus.si),   32'd0);
        check("mid rst done", 32'(bus.done), 32'd0);
        @(negedge cp);
        cdn = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge cp);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("no done after abort", 32'(done_cnt), 32'd0);
        mc = '0;
        run_op(8'h81, 1'b0, 1'b0, N, 8'h00, 8'h81, "post rst");
        idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
